// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO fed over valid/ready,
// drained by a start/data/stop shifter that drives a registered serial line.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic                         tx_o,
    output logic                         busy_o,
    output logic [$clog2(FIFO_DEPTH):0]  count_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [2:0]         idx, idx_n;
    logic [7:0]         shift, shift_n;
    logic               tx_q, tx_n;
    logic               pop;
    logic               push;
    logic               baud_last;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   head, tail;
    logic [PTR_W:0]     count;

    // Accept decisions use only the registered count, never a same-cycle pop.
    assign ready_o   = (count < DEPTH_C);
    assign push      = valid_i && ready_o;
    assign baud_last = (cnt == BAUD_LAST);

    assign tx_o    = tx_q;
    assign count_o = count;
    assign busy_o  = (state != IDLE) || (count != '0);

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= data_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Transmitter state register; the line level is registered so it never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            tx_q  <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            tx_q  <= tx_n;
        end
    end

    // Shift register holds the byte being sent; loaded only on a pop.
    always_ff @(posedge clk) begin
        shift <= shift_n;
    end

    // Next-state logic: bit timing, bit index, FIFO pop and next line level.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        tx_n    = tx_q;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (count != '0) begin
                    pop     = 1'b1;
                    state_n = START;
                    cnt_n   = '0;
                    shift_n = mem[head];
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    state_n = DATA;
                    cnt_n   = '0;
                    idx_n   = 3'd0;
                    tx_n    = shift[0];
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    cnt_n = '0;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        idx_n = idx + 3'd1;
                        tx_n  = shift[idx + 3'd1];
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    cnt_n = '0;
                    if (count != '0) begin
                        pop     = 1'b1;
                        state_n = START;
                        shift_n = mem[head];
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter, the transmit end of the glitcher's host serial link: it accepts bytes from the command/response logic over a valid/ready handshake, queues them in a small FIFO and serialises them onto the `uart_tx` pin. It is the counterpart to the UART receiver used for inbound host commands. It has the same baud parameterisation, so both ends of the link agree on bit timing.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate. `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE`, with integer division truncating. Must be ≥ 2.
- `FIFO_DEPTH`, default 4: queue entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock. This is the single clock domain.
- `rst`  in  1  reset. Synchronous and active-high.
- `data_i`  in  8  byte to transmit.
- `valid_i`  in  1  `data_i` is valid.
- `ready_o`  out  1  FIFO can accept a byte this cycle.
- `tx_o`  out  1  serial line. Idles high.
- `busy_o`  out  1  a frame is in progress or the FIFO is non-empty.
- `count_o`  out  $clog2(FIFO_DEPTH)+1  number of queued bytes. This count excludes the byte in the shifter.

## Operation
- **Reset values:** `tx_o`=1, `ready_o`=1, `busy_o`=0, `count_o`=0. The FIFO is emptied and the state machine is in IDLE.
- **Push:** a byte is accepted on a rising edge where `valid_i && ready_o`.
  - `ready_o = (count_o < FIFO_DEPTH)`. It depends only on the registered count, not on a same-cycle pop.
  - `valid_i` while `ready_o`=0 is ignored. The byte is not stored and there is no error flag.
- **Pop:** the shifter takes the FIFO head when it is in IDLE with the FIFO non-empty, or in the final cycle of STOP with the FIFO non-empty.
- **Push and pop together:** count is unchanged. Head and tail pointers both advance and wrap modulo `FIFO_DEPTH`.
- **Frame format:** start bit (0), data bits 0..7 LSB first, stop bit (1). No parity. Each bit is held for exactly `CLKS_PER_BIT` cycles.
- **State machine:**
  - IDLE: `tx_o`=1. Goes to START on pop.
  - START: `tx_o`=0 for `CLKS_PER_BIT` cycles, then DATA with bit index 0.
  - DATA: `tx_o`=shift[idx]. After `CLKS_PER_BIT` cycles, idx increments. Leaves to STOP after idx 7.
  - STOP: `tx_o`=1 for `CLKS_PER_BIT` cycles. On the last cycle, goes to START if the FIFO is non-empty (pop), otherwise to IDLE.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1 and reloads to 0 on every bit boundary and on every pop.
- **Output registers:** `tx_o` comes directly from a flop, so the line has no combinational glitches.
- **busy_o:** `= (state != IDLE) || (count_o != 0)`. Registered or equivalent, as long as it follows the cycle timing below.

## Timing
- **Accept to start bit:** a byte accepted at edge E while the transmitter is idle and the FIFO empty is popped at edge E+1. `tx_o` is 0 from E+1.
- **Frame length:** exactly 10·`CLKS_PER_BIT` cycles, from the start-bit edge to the end of the stop bit.
- **Back-to-back frames:** no idle gap between them. The next start bit begins on the cycle immediately after the last stop-bit cycle.
- **count_o:** reflects pushes and pops at the edge on which they occur.
- **Reset mid-frame:** reset asserted at any edge aborts the frame. `tx_o`=1 from that edge and all queued bytes are discarded.
  - Reset held for multiple cycles keeps every output at its reset value.
  - After reset deasserts, the first accepted byte follows the accept-to-start-bit rule above.
- **Divisor truncation:** at CLK_FREQ=50 MHz and BAUD_RATE=115200, `CLKS_PER_BIT`=434 and a frame is 4340 cycles.

## Test plan
- **Single byte:** CLK_FREQ=1000, BAUD_RATE=100 (10 clk/bit). Push 0xA5 at edge E.
  - `tx_o` is 0 for E+1..E+10.
  - Data bits, 10 cycles each: 1,0,1,0,0,1,0,1.
  - `tx_o` is 1 for E+91..E+100.
  - `busy_o` is 1 until E+100 and 0 from E+101.
- **Fill and backpressure:** same parameters, FIFO_DEPTH=4. Hold `valid_i` high with bytes 0x01..0x06.
  - Bytes 0x01..0x05 are accepted on 5 consecutive edges (0x01 pops immediately). `ready_o` goes low after the 5th accept with `count_o`=4.
  - 0x06 is accepted one cycle after the pop of 0x02 at the end of frame 1.
  - The line shows six contiguous frames, 600 cycles total, in order 0x01..0x06.
- **Ignored push:** `valid_i` with byte 0xFF while `ready_o`=0 → 0xFF never appears on `tx_o` and `count_o` is unchanged.
- **Reset mid-frame:** assert `rst` during data bit 3 of 0x3C with 2 bytes queued.
  - `tx_o`=1, `count_o`=0, `busy_o`=0 and `ready_o`=1 from the reset edge.
  - After release, push 0x81 → one clean frame of 0x81 only.
- **Default divisor:** CLK_FREQ=50_000_000, BAUD_RATE=115200, push 0x00.
  - Start and data low for 3906 cycles (9·434).
  - Stop bit high for 434 cycles.
  - Line idle afterwards.
- **Wrap-around:** FIFO_DEPTH=4. Push and pop 13 bytes 0x10..0x1C, pacing pushes so `count_o` stays between 1 and 3 → all 13 bytes are transmitted in order and the pointers wrap at least 3 times without loss.
